decode_pipe: RTL and testbench

Parametrised, pipelined MIPS instruction decode stage sitting between fetch and register-read/execute. It accepts one instruction word plus PC per cycle over a valid/ready handshake and classifies it as R/I/J/illegal. It emits raw fields, an extended immediate, jump target and destination-register/write-enable decisions. A two-entry skid buffer gives full throughput under back-pressure, and a synchronous flush supports branch redirects.

---
 rtl/decode_pkg.sv | 87 ++++++++
 rtl/decode_fields.sv | 116 +++++++++++
 rtl/decode_pipe.sv | 110 +++++++++++
 tb/tb_decode_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// MIPS decode constants, instruction class encoding and the decoded record stored by the pipe.
// No logic of its own; shared by decode_fields and decode_pipe.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;
  localparam logic [4:0] REG_RA  = 5'd31;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_J   = 2'd2,
    CLS_ILL = 2'd3
  } insn_class_t;

  // PC and immediate are width-parameterised, so they live beside the record.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [25:0] jtarget;
    insn_class_t cls;
    logic [4:0]  dest;
    logic        regwrite;
  } dec_rec_t;

  function automatic logic r_func_legal(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_JALR,
      F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU,
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
      F_SLT, F_SLTU: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational MIPS decode: instruction word -> decoded record plus extended immediate.
// Zero latency, no handshake; IMM_WIDTH must be at least 18 so branch offsets fit.
module decode_fields
  import decode_pkg::*;
#(
  parameter int IMM_WIDTH = 32
) (
  input  logic [31:0]          insn,
  output dec_rec_t             rec,
  output logic [IMM_WIDTH-1:0] imm
);

  typedef enum logic [2:0] {
    IMM_ZERO,
    IMM_SEXT,
    IMM_ZEXT,
    IMM_LUI,
    IMM_BR
  } imm_kind_t;

  logic [5:0] opcode;
  logic [5:0] func;
  logic [4:0] rt;
  logic [4:0] rd;
  imm_kind_t  kind;
  insn_class_t cls;
  logic [4:0] dest;
  logic [IMM_WIDTH-1:0] sext;
  logic [IMM_WIDTH-1:0] zext;

  assign opcode = insn[31:26];
  assign func   = insn[5:0];
  assign rt     = insn[20:16];
  assign rd     = insn[15:11];
  assign sext   = {{(IMM_WIDTH-16){insn[15]}}, insn[15:0]};
  assign zext   = {{(IMM_WIDTH-16){1'b0}}, insn[15:0]};

  always_comb begin
    kind = IMM_ZERO;
    cls  = CLS_ILL;
    dest = '0;
    case (opcode)
      OP_RTYPE: begin
        if (r_func_legal(func)) begin
          cls = CLS_R;
          case (func)
            F_MULT, F_MULTU, F_DIV, F_DIVU, F_JR: dest = '0;
            default:                              dest = rd;
          endcase
        end
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ) begin
          cls  = CLS_I;
          kind = IMM_BR;
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        cls  = CLS_I;
        kind = IMM_BR;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_LB, OP_LBU: begin
        cls  = CLS_I;
        kind = IMM_SEXT;
        dest = rt;
      end
      OP_SW, OP_SB: begin
        cls  = CLS_I;
        kind = IMM_SEXT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        cls  = CLS_I;
        kind = IMM_ZEXT;
        dest = rt;
      end
      OP_LUI: begin
        cls  = CLS_I;
        kind = IMM_LUI;
        dest = rt;
      end
      OP_J: cls = CLS_J;
      OP_JAL: begin
        cls  = CLS_J;
        dest = REG_RA;
      end
      default: ;
    endcase
  end

  // LUI and branch shifts drop bits above IMM_WIDTH when the output is narrow.
  always_comb begin
    imm = '0;
    case (kind)
      IMM_SEXT: imm = sext;
      IMM_ZEXT: imm = zext;
      IMM_LUI:  imm = zext << 16;
      IMM_BR:   imm = sext << 2;
      default:  imm = '0;
    endcase
  end

  always_comb begin
    rec          = '0;
    rec.opcode   = opcode;
    rec.rs       = insn[25:21];
    rec.rt       = rt;
    rec.rd       = rd;
    rec.sa       = insn[10:6];
    rec.func     = func;
    rec.jtarget  = insn[25:0];
    rec.cls      = cls;
    rec.dest     = dest;
    rec.regwrite = (dest != 5'd0) && (cls != CLS_ILL);
  end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined MIPS decode stage, 1-cycle latency, full throughput; flush drops everything held.
// SKID=1: out register plus one skid entry, in_ready registered; SKID=0: single entry, in_ready combinational.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 32,
  parameter bit SKID      = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_insn,
  input  logic [PC_WIDTH-1:0]  in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [5:0]           out_opcode,
  output logic [4:0]           out_rs,
  output logic [4:0]           out_rt,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_sa,
  output logic [5:0]           out_func,
  output logic [IMM_WIDTH-1:0] out_imm,
  output logic [25:0]          out_jtarget,
  output logic [1:0]           out_class,
  output logic [4:0]           out_dest,
  output logic                 out_regwrite
);

  dec_rec_t             dec_rec;
  logic [IMM_WIDTH-1:0] dec_imm;

  dec_rec_t             out_rec;
  logic [IMM_WIDTH-1:0] out_imm_q;
  logic [PC_WIDTH-1:0]  out_pc_q;

  logic                 skid_valid;
  dec_rec_t             skid_rec;
  logic [IMM_WIDTH-1:0] skid_imm;
  logic [PC_WIDTH-1:0]  skid_pc;

  logic out_free;
  logic accept;

  decode_fields #(
    .IMM_WIDTH(IMM_WIDTH)
  ) u_fields (
    .insn(in_insn),
    .rec (dec_rec),
    .imm (dec_imm)
  );

  assign out_free = !out_valid || out_ready;
  assign in_ready = SKID ? !skid_valid : out_free;
  assign accept   = in_valid && in_ready;

  // With SKID=0 in_ready equals out_free, so the skid branch is never taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_rec    <= '0;
      out_imm_q  <= '0;
      out_pc_q   <= '0;
      skid_valid <= 1'b0;
      skid_rec   <= '0;
      skid_imm   <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_rec    <= skid_rec;
        out_imm_q  <= skid_imm;
        out_pc_q   <= skid_pc;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_rec   <= dec_rec;
        out_imm_q <= dec_imm;
        out_pc_q  <= in_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_rec   <= dec_rec;
      skid_imm   <= dec_imm;
      skid_pc    <= in_pc;
    end
  end

  assign out_pc       = out_pc_q;
  assign out_imm      = out_imm_q;
  assign out_opcode   = out_rec.opcode;
  assign out_rs       = out_rec.rs;
  assign out_rt       = out_rec.rt;
  assign out_rd       = out_rec.rd;
  assign out_sa       = out_rec.sa;
  assign out_func     = out_rec.func;
  assign out_jtarget  = out_rec.jtarget;
  assign out_class    = out_rec.cls;
  assign out_dest     = out_rec.dest;
  assign out_regwrite = out_rec.regwrite;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: SKID=1/IMM_WIDTH=32 and SKID=0/IMM_WIDTH=18 instances side by side.
module tb_decode_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  func;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [1:0]  cls;
    logic [4:0]  dest;
    logic        rw;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_insn [2];
  logic [31:0] in_pc [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_pc [2];
  logic [5:0]  out_opcode [2];
  logic [4:0]  out_rs [2];
  logic [4:0]  out_rt [2];
  logic [4:0]  out_rd [2];
  logic [4:0]  out_sa [2];
  logic [5:0]  out_func [2];
  logic [31:0] out_imm_w [2];
  logic [17:0] imm18;
  logic [25:0] out_jtarget [2];
  logic [1:0]  out_class [2];
  logic [4:0]  out_dest [2];
  logic        out_regwrite [2];

  exp_t sbq [2][$];

  logic [5:0]  ops [20];
  logic [5:0]  funcs [24];
  logic [31:0] dir [15];

  always #5 clock = ~clock;

  decode_pipe #(.PC_WIDTH(32), .IMM_WIDTH(32), .SKID(1'b1)) dut_skid (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_insn(in_insn[0]), .in_pc(in_pc[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pc(out_pc[0]),
    .out_opcode(out_opcode[0]), .out_rs(out_rs[0]), .out_rt(out_rt[0]), .out_rd(out_rd[0]),
    .out_sa(out_sa[0]), .out_func(out_func[0]), .out_imm(out_imm_w[0]),
    .out_jtarget(out_jtarget[0]), .out_class(out_class[0]), .out_dest(out_dest[0]),
    .out_regwrite(out_regwrite[0])
  );

  decode_pipe #(.PC_WIDTH(32), .IMM_WIDTH(18), .SKID(1'b0)) dut_single (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_insn(in_insn[1]), .in_pc(in_pc[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pc(out_pc[1]),
    .out_opcode(out_opcode[1]), .out_rs(out_rs[1]), .out_rt(out_rt[1]), .out_rd(out_rd[1]),
    .out_sa(out_sa[1]), .out_func(out_func[1]), .out_imm(imm18),
    .out_jtarget(out_jtarget[1]), .out_class(out_class[1]), .out_dest(out_dest[1]),
    .out_regwrite(out_regwrite[1])
  );

  assign out_imm_w[1] = {14'h0, imm18};

  // Reference decode from the instruction-set rules; immw truncates the immediate.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input int immw);
    exp_t e;
    int s;
    logic [31:0] imm;
    logic [5:0] fn;
    e = '0;
    e.pc = pc; e.opcode = w[31:26]; e.rs = w[25:21]; e.rt = w[20:16];
    e.rd = w[15:11]; e.sa = w[10:6]; e.func = w[5:0]; e.jt = w[25:0];
    fn = w[5:0];
    s = int'($signed(w[15:0]));
    e.cls = 2'd3; e.dest = 5'd0; imm = 32'd0;
    case (w[31:26])
      6'h00: if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12,
                            6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h24, 6'h25,
                            6'h26, 6'h27, 6'h09, 6'h08}) begin
        e.cls = 2'd0;
        e.dest = (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h08}) ? 5'd0 : w[15:11];
      end
      6'h01: if (w[20:16] <= 5'd1) begin e.cls = 2'd1; imm = s * 4; end
      6'h02: e.cls = 2'd2;
      6'h03: begin e.cls = 2'd2; e.dest = 5'd31; end
      6'h04, 6'h05, 6'h06, 6'h07: begin e.cls = 2'd1; imm = s * 4; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h23, 6'h24: begin e.cls = 2'd1; imm = s; e.dest = w[20:16]; end
      6'h28, 6'h2B: begin e.cls = 2'd1; imm = s; end
      6'h0C, 6'h0D, 6'h0E: begin e.cls = 2'd1; imm = 32'(w[15:0]); e.dest = w[20:16]; end
      6'h0F: begin e.cls = 2'd1; imm = 32'(w[15:0]) * 32'd65536; e.dest = w[20:16]; end
      default: ;
    endcase
    if (immw < 32) imm = imm % (32'd1 << immw);
    e.imm = imm;
    e.rw = (e.dest != 5'd0) && (e.cls != 2'd3);
    return e;
  endfunction

  function automatic logic [31:0] gen_insn();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      r[31:26] = ops[$urandom_range(0, 19)];
      if (r[31:26] == 6'h00 && $urandom_range(0, 4) != 0) r[5:0] = funcs[$urandom_range(0, 23)];
      if (r[31:26] == 6'h01) r[20:16] = 5'($urandom_range(0, 2));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: held entries == queue depth; head must be presented and stay stable until taken.
  always @(negedge clock) begin
    if (reset) begin
      sbq[0].delete();
      sbq[1].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int n;
        bit erdy;
        exp_t act;
        n = sbq[i].size();
        erdy = (i == 0) ? (n < 2) : (out_ready[i] || n == 0);
        chk($sformatf("in_ready%0d", i), {31'd0, in_ready[i]}, {31'd0, erdy});
        chk($sformatf("out_valid%0d", i), {31'd0, out_valid[i]}, {31'd0, n != 0});
        if (out_valid[i] && n != 0) begin
          act.pc = out_pc[i]; act.opcode = out_opcode[i]; act.rs = out_rs[i]; act.rt = out_rt[i];
          act.rd = out_rd[i]; act.sa = out_sa[i]; act.func = out_func[i]; act.imm = out_imm_w[i];
          act.jt = out_jtarget[i]; act.cls = out_class[i]; act.dest = out_dest[i];
          act.rw = out_regwrite[i];
          chk_rec($sformatf("record%0d", i), act, sbq[i][0]);
        end
        if (flush) begin
          sbq[i].delete();
        end else begin
          if (out_valid[i] && out_ready[i] && n != 0) void'(sbq[i].pop_front());
          if (in_valid[i] && erdy) sbq[i].push_back(model(in_insn[i], in_pc[i], (i == 0) ? 32 : 18));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int p, input logic [31:0] insn, input logic [31:0] pc,
                      input int budget, output bit ok);
    in_valid[p] = 1'b1;
    in_insn[p]  = insn;
    in_pc[p]    = pc;
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clock);
      if (in_ready[p]) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    if (ok) in_valid[p] = 1'b0;
  endtask

  initial begin
    bit ok;
    int k;
    logic [31:0] sins [3];
    ops   = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
              6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B};
    funcs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h2A, 6'h2B,
              6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h24, 6'h25, 6'h26, 6'h27, 6'h09, 6'h08};
    dir   = '{32'h00221820, 32'h00000000, 32'h2485FFFC, 32'h34858000, 32'h3C011234,
              32'h1022FFFF, 32'h0C100000, 32'hFC000000, 32'h0000003F, 32'h04010003,
              32'h04020003, 32'h8C450010, 32'hAC450010, 32'h00200008, 32'h0022001A};
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 1'b0; in_insn[p] = '0; in_pc[p] = '0; out_ready[p] = 1'b0;
    end
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int p = 0; p < 2; p++) begin
      chk("rst_out_valid", {31'd0, out_valid[p]}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready[p]}, 32'd1);
      chk("rst_out_pc", out_pc[p], 32'd0);
      chk("rst_out_imm", out_imm_w[p], 32'd0);
      chk("rst_out_dest", {27'd0, out_dest[p]}, 32'd0);
    end
    step();

    for (int p = 0; p < 2; p++) begin
      out_ready[p] = 1'b1;
      for (int j = 0; j < 15; j++) begin
        in_valid[p] = 1'b1; in_insn[p] = dir[j]; in_pc[p] = 32'(j * 4);
        step();
      end
      in_valid[p] = 1'b0;
      repeat (3) step();

      // Stream 0x0/0x4/0x8 into a stalled stage; the rest stays held upstream.
      for (int j = 0; j < 3; j++) sins[j] = gen_insn();
      out_ready[p] = 1'b0;
      k = 0;
      while (k < 3) begin
        send(p, sins[k], 32'(k * 4), 4, ok);
        if (!ok) break;
        k++;
      end
      chk("stream_accepts", k, (p == 0) ? 32'd2 : 32'd1);
      out_ready[p] = 1'b1;
      while (k < 3) begin
        send(p, sins[k], 32'(k * 4), 20, ok);
        chk("stream_accept_timeout", {31'd0, ok}, 32'd1);
        if (!ok) break;
        k++;
      end
      in_valid[p] = 1'b0;
      repeat (5) step();

      out_ready[p] = 1'b0;
      for (int j = 0; j < ((p == 0) ? 2 : 1); j++) begin
        send(p, gen_insn(), 32'h100 + 32'(j * 4), 10, ok);
        chk("flush_fill", {31'd0, ok}, 32'd1);
      end
      in_valid[p] = 1'b1; in_insn[p] = gen_insn(); in_pc[p] = 32'h200; flush = 1'b1;
      step();
      flush = 1'b0; in_valid[p] = 1'b0;
      @(negedge clock);
      chk("flush_out_valid", {31'd0, out_valid[p]}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready[p]}, 32'd1);
      out_ready[p] = 1'b1;
      repeat (4) step();
    end

    repeat (800) begin
      for (int p = 0; p < 2; p++) begin
        in_valid[p]  = ($urandom_range(0, 9) < 7);
        in_insn[p]   = gen_insn();
        in_pc[p]     = $urandom & 32'hFFFF_FFFC;
        out_ready[p] = ($urandom_range(0, 9) < 6);
      end
      flush = ($urandom_range(0, 59) == 0);
      step();
    end
    flush = 1'b0;

    // Reset while both stages hold data and an input is pending.
    for (int p = 0; p < 2; p++) begin
      out_ready[p] = 1'b0; in_valid[p] = 1'b1; in_insn[p] = gen_insn(); in_pc[p] = 32'h300;
    end
    repeat (3) step();
    reset = 1'b1;
    #2;
    for (int p = 0; p < 2; p++) begin
      chk("midrst_out_valid", {31'd0, out_valid[p]}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready[p]}, 32'd1);
    end
    step();
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      in_valid[p] = 1'b0; out_ready[p] = 1'b1;
    end
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
